sp_divider: RTL and testbench

- Iterative IEEE-754 single-precision divider (result = operand_a / operand_b), the inverse-operation companion to the FPU multiplier in fpu_modules.
- Uses the same start/done handshake and the same flag set as the multiplier, plus divide-by-zero.
- Restoring radix-2 quotient generation, one bit per cycle, then normalize, optional denormalize, and round.
- Feeds the FPU result mux alongside the multiplier.

---
 rtl/sp_divider.sv | 249 ++++++++++++++++++++++++
 tb/tb_sp_divider.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sp_divider.sv
// Iterative IEEE-754 single-precision divider: restoring radix-2 quotient, one bit
// per cycle, followed by normalize, optional denormalize and round.
module sp_divider (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  input  logic [2:0]  rounding_mode,
  output logic [31:0] result,
  output logic        flag_invalid,
  output logic        flag_divzero,
  output logic        flag_overflow,
  output logic        flag_underflow,
  output logic        flag_inexact,
  output logic        done
);
  localparam int QBITS = 27;

  // Handshake: start is sampled only in IDLE; done pulses for exactly one cycle when
  // result and flags are written, and both then hold until the next accepted start.
  typedef enum logic [2:0] {
    S_IDLE, S_SPECIAL, S_PRENORM, S_DIVIDE, S_POSTNORM, S_DENORM, S_ROUND, S_DONE
  } state_t;

  state_t             state_q;
  logic [31:0]        a_q, b_q;
  logic               sign_q, tiny_q;
  logic signed [11:0] exp_q;
  logic [23:0]        ma_q, mb_q, mant_q;
  logic [25:0]        rem_q;
  logic [QBITS-1:0]   quo_q;
  logic [4:0]         cnt_q;
  logic               g_q, r_q, s_q;

  logic [7:0]  ea, eb, ea_eff, eb_eff;
  logic [22:0] fa, fb;
  logic        a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero, sgn;

  assign ea     = a_q[30:23];
  assign eb     = b_q[30:23];
  assign fa     = a_q[22:0];
  assign fb     = b_q[22:0];
  assign ea_eff = (ea == 8'd0) ? 8'd1 : ea;
  assign eb_eff = (eb == 8'd0) ? 8'd1 : eb;
  assign a_nan  = (ea == 8'hFF) && (fa != 23'd0);
  assign b_nan  = (eb == 8'hFF) && (fb != 23'd0);
  assign a_snan = a_nan && !fa[22];
  assign b_snan = b_nan && !fb[22];
  assign a_inf  = (ea == 8'hFF) && (fa == 23'd0);
  assign b_inf  = (eb == 8'hFF) && (fb == 23'd0);
  assign a_zero = (ea == 8'd0) && (fa == 23'd0);
  assign b_zero = (eb == 8'd0) && (fb == 23'd0);
  assign sgn    = a_q[31] ^ b_q[31];

  logic        q_bit;
  logic [25:0] rem_sub;
  assign q_bit   = (rem_q >= {2'b00, mb_q});
  assign rem_sub = q_bit ? (rem_q - {2'b00, mb_q}) : rem_q;

  logic [23:0]        pn_mant;
  logic               pn_g, pn_r, pn_s;
  logic signed [11:0] pn_exp;
  always_comb begin
    if (quo_q[26]) begin
      pn_mant = quo_q[26:3];
      pn_g    = quo_q[2];
      pn_r    = quo_q[1];
      pn_s    = quo_q[0] | (|rem_q);
      pn_exp  = exp_q;
    end else begin
      pn_mant = quo_q[25:2];
      pn_g    = quo_q[1];
      pn_r    = quo_q[0];
      pn_s    = |rem_q;
      pn_exp  = exp_q - 12'sd1;
    end
  end

  logic               rnd_nx, rnd_up, rnd_ovf;
  logic [24:0]        rnd_sum;
  logic signed [11:0] rnd_exp;
  logic [22:0]        rnd_frac;
  logic [7:0]         rnd_efield;
  always_comb begin
    rnd_nx = g_q | r_q | s_q;
    case (rounding_mode)
      3'b000:  rnd_up = g_q & (mant_q[0] | r_q | s_q);
      3'b010:  rnd_up = rnd_nx & sign_q;
      3'b011:  rnd_up = rnd_nx & ~sign_q;
      3'b100:  rnd_up = g_q;
      default: rnd_up = 1'b0;
    endcase
    rnd_sum  = {1'b0, mant_q} + {24'd0, rnd_up};
    rnd_exp  = exp_q;
    rnd_frac = rnd_sum[22:0];
    if (rnd_sum[24]) begin
      rnd_exp  = exp_q + 12'sd1;
      rnd_frac = 23'd0;
    end
    // A denormal that rounds up into bit 23 becomes the smallest normal.
    rnd_efield = tiny_q ? {7'd0, rnd_sum[23]} : rnd_exp[7:0];
    rnd_ovf    = !tiny_q && (rnd_exp > 12'sd254);
  end

  function automatic logic [31:0] ovf_value(input logic s, input logic [2:0] rm);
    logic to_inf;
    case (rm)
      3'b000, 3'b100: to_inf = 1'b1;
      3'b010:         to_inf = s;
      3'b011:         to_inf = ~s;
      default:        to_inf = 1'b0;
    endcase
    return to_inf ? {s, 8'hFF, 23'd0} : {s, 8'hFE, 23'h7FFFFF};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      result         <= 32'd0;
      flag_invalid   <= 1'b0;
      flag_divzero   <= 1'b0;
      flag_overflow  <= 1'b0;
      flag_underflow <= 1'b0;
      flag_inexact   <= 1'b0;
      done           <= 1'b0;
      a_q            <= 32'd0;
      b_q            <= 32'd0;
      sign_q         <= 1'b0;
      tiny_q         <= 1'b0;
      exp_q          <= 12'sd0;
      ma_q           <= 24'd0;
      mb_q           <= 24'd0;
      mant_q         <= 24'd0;
      rem_q          <= 26'd0;
      quo_q          <= '0;
      cnt_q          <= 5'd0;
      g_q            <= 1'b0;
      r_q            <= 1'b0;
      s_q            <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            a_q            <= operand_a;
            b_q            <= operand_b;
            flag_invalid   <= 1'b0;
            flag_divzero   <= 1'b0;
            flag_overflow  <= 1'b0;
            flag_underflow <= 1'b0;
            flag_inexact   <= 1'b0;
            tiny_q         <= 1'b0;
            state_q        <= S_SPECIAL;
          end
        end
        S_SPECIAL: begin
          sign_q  <= sgn;
          done    <= 1'b1;
          state_q <= S_DONE;
          if (a_nan || b_nan) begin
            result       <= 32'h7FC00000;
            flag_invalid <= a_snan | b_snan;
          end else if ((a_inf && b_inf) || (a_zero && b_zero)) begin
            result       <= 32'h7FC00000;
            flag_invalid <= 1'b1;
          end else if (a_inf) begin
            result <= {sgn, 8'hFF, 23'd0};
          end else if (b_inf || a_zero) begin
            result <= {sgn, 31'd0};
          end else if (b_zero) begin
            result       <= {sgn, 8'hFF, 23'd0};
            flag_divzero <= 1'b1;
          end else begin
            done    <= 1'b0;
            exp_q   <= $signed({4'd0, ea_eff}) - $signed({4'd0, eb_eff}) + 12'sd127;
            ma_q    <= {(ea != 8'd0), fa};
            mb_q    <= {(eb != 8'd0), fb};
            state_q <= S_PRENORM;
          end
        end
        S_PRENORM: begin
          if (!ma_q[23]) begin
            ma_q  <= ma_q << 1;
            exp_q <= exp_q - 12'sd1;
          end else if (!mb_q[23]) begin
            mb_q  <= mb_q << 1;
            exp_q <= exp_q + 12'sd1;
          end else begin
            rem_q   <= {2'b00, ma_q};
            quo_q   <= '0;
            cnt_q   <= 5'd0;
            state_q <= S_DIVIDE;
          end
        end
        S_DIVIDE: begin
          quo_q <= {quo_q[QBITS-2:0], q_bit};
          rem_q <= rem_sub << 1;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'(QBITS - 1)) state_q <= S_POSTNORM;
        end
        S_POSTNORM: begin
          mant_q <= pn_mant;
          g_q    <= pn_g;
          r_q    <= pn_r;
          s_q    <= pn_s;
          if (pn_exp > 12'sd254) begin
            result        <= ovf_value(sign_q, rounding_mode);
            flag_overflow <= 1'b1;
            flag_inexact  <= 1'b1;
            done          <= 1'b1;
            state_q       <= S_DONE;
          end else if (pn_exp < 12'sd1) begin
            // 26 shifts already empty {mant,G,R} into S; never shift further.
            exp_q   <= (pn_exp < -12'sd25) ? -12'sd25 : pn_exp;
            tiny_q  <= 1'b1;
            state_q <= S_DENORM;
          end else begin
            exp_q   <= pn_exp;
            state_q <= S_ROUND;
          end
        end
        S_DENORM: begin
          mant_q <= {1'b0, mant_q[23:1]};
          g_q    <= mant_q[0];
          r_q    <= g_q;
          s_q    <= s_q | r_q;
          exp_q  <= exp_q + 12'sd1;
          if (exp_q == 12'sd0) state_q <= S_ROUND;
        end
        S_ROUND: begin
          if (rnd_ovf) begin
            result        <= ovf_value(sign_q, rounding_mode);
            flag_overflow <= 1'b1;
            flag_inexact  <= 1'b1;
          end else begin
            result         <= {sign_q, rnd_efield, rnd_frac};
            flag_inexact   <= rnd_nx;
            flag_underflow <= tiny_q & rnd_nx;
          end
          done    <= 1'b1;
          state_q <= S_DONE;
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sp_divider.sv
// Bench for sp_divider: directed cases with fixed expectations plus random operands
// scored against an exact integer-arithmetic model of IEEE division and rounding.
module tb_sp_divider;
  logic        clk = 1'b0;
  logic        rst, start;
  logic [31:0] operand_a, operand_b;
  logic [2:0]  rounding_mode;
  logic [31:0] result;
  logic        flag_invalid, flag_divzero, flag_overflow, flag_underflow, flag_inexact;
  logic        done;

  int          n_checks = 0;
  int          n_errs   = 0;
  logic [36:0] exp_q[$];

  localparam int MAX_WAIT = 400;

  sp_divider dut (
    .clk(clk), .rst(rst), .start(start),
    .operand_a(operand_a), .operand_b(operand_b), .rounding_mode(rounding_mode),
    .result(result), .flag_invalid(flag_invalid), .flag_divzero(flag_divzero),
    .flag_overflow(flag_overflow), .flag_underflow(flag_underflow),
    .flag_inexact(flag_inexact), .done(done)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] ovf_ref(input logic s, input logic [2:0] rm);
    logic inf;
    case (rm)
      3'd0, 3'd4: inf = 1'b1;
      3'd2:       inf = s;
      3'd3:       inf = !s;
      default:    inf = 1'b0;
    endcase
    return inf ? {s, 31'h7F800000} : {s, 31'h7F7FFFFF};
  endfunction

  // Exact quotient via wide integer division; {result, nv, dz, of, uf, nx}.
  function automatic logic [36:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] rm);
    logic s, a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero;
    logic guard, sticky, nx, up, tiny;
    logic [22:0]  fa, fb;
    logic [127:0] num, den, q, rmd, keep;
    int ea, eb, p, scale, e, shift, biased;
    s = a[31] ^ b[31];
    ea = int'(a[30:23]); eb = int'(b[30:23]);
    fa = a[22:0]; fb = b[22:0];
    a_nan = (ea == 255) && (fa != 0); b_nan = (eb == 255) && (fb != 0);
    a_snan = a_nan && !fa[22]; b_snan = b_nan && !fb[22];
    a_inf = (ea == 255) && (fa == 0); b_inf = (eb == 255) && (fb == 0);
    a_zero = (ea == 0) && (fa == 0); b_zero = (eb == 0) && (fb == 0);
    if (a_nan || b_nan) return {32'h7FC00000, a_snan || b_snan, 4'b0000};
    if ((a_inf && b_inf) || (a_zero && b_zero)) return {32'h7FC00000, 5'b10000};
    if (a_inf) return {s, 31'h7F800000, 5'b00000};
    if (b_inf || a_zero) return {s, 31'd0, 5'b00000};
    if (b_zero) return {s, 31'h7F800000, 5'b01000};
    num = {104'd0, (ea != 0), fa} << 60;
    den = {104'd0, (eb != 0), fb};
    q = num / den;
    rmd = num % den;
    p = 0;
    for (int i = 0; i < 128; i++) if (q[i]) p = i;
    scale = ((ea == 0) ? 1 : ea) - ((eb == 0) ? 1 : eb) - 60;
    e = p + scale;
    tiny = (e < -126);
    shift = ((tiny ? -126 : e) - 23) - scale;
    if (shift >= 120) begin
      keep = 0; guard = 1'b0; sticky = 1'b1;
    end else begin
      keep = q >> shift;
      guard = q[shift-1];
      sticky = ((q & ((128'd1 << (shift - 1)) - 128'd1)) != 0) || (rmd != 0);
    end
    nx = guard | sticky;
    case (rm)
      3'd0:    up = guard & (keep[0] | sticky);
      3'd2:    up = nx & s;
      3'd3:    up = nx & !s;
      3'd4:    up = guard;
      default: up = 1'b0;
    endcase
    keep = keep + {127'd0, up};
    if (!tiny && keep[24]) begin
      keep = keep >> 1;
      e++;
    end
    biased = tiny ? (keep[23] ? 1 : 0) : e + 127;
    if (biased > 254) return {ovf_ref(s, rm), 5'b00101};
    return {s, 8'(biased), keep[22:0], 3'b000, tiny & nx, nx};
  endfunction

  function automatic logic [31:0] rand_operand(input int kind);
    logic [31:0] v;
    v = $urandom;
    case (kind)
      1:       v[30:23] = 8'($urandom_range(100, 154));
      2:       v[30:23] = 8'h00;
      3:       v[30:23] = 8'($urandom_range(200, 254));
      4:       v[30:23] = 8'($urandom_range(1, 40));
      5: begin
        v[30:23] = 8'hFF;
        if ($urandom_range(0, 1) == 1) v[22:0] = 23'd0;
      end
      6:       v[30:0] = 31'd0;
      default: ;
    endcase
    return v;
  endfunction

  // driver tasks
  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < MAX_WAIT) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic score(input string tag, input int lat, input int exp_lat);
    logic [36:0] want;
    check({tag, " done"}, 64'(done), 64'd1);
    want = exp_q.pop_front();
    check({tag, " result"}, 64'(result), 64'(want[36:5]));
    check({tag, " flags"},
          64'({flag_invalid, flag_divzero, flag_overflow, flag_underflow, flag_inexact}),
          64'(want[4:0]));
    if (exp_lat >= 0) check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    @(negedge clk);
    check({tag, " pulse"}, 64'(done), 64'd0);
  endtask

  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] rm,
                       input logic [36:0] expv, input int exp_lat, input string tag);
    int lat;
    exp_q.push_back(expv);
    @(negedge clk);
    operand_a = a; operand_b = b; rounding_mode = rm; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_done(lat);
    score(tag, lat, exp_lat);
  endtask

  initial begin
    int lat, seen, ka, kb;
    logic [31:0] ra, rb;
    logic [2:0]  rm;
    rst = 1'b1; start = 1'b0; operand_a = '0; operand_b = '0; rounding_mode = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset result", 64'(result), 64'd0);
    check("reset flags", 64'({flag_invalid, flag_divzero, flag_overflow, flag_underflow,
                              flag_inexact}), 64'd0);
    check("reset done", 64'(done), 64'd0);

    do_op(32'h40C00000, 32'h40000000, 3'd0, {32'h40400000, 5'b00000}, 31, "six_by_two");
    do_op(32'h3F800000, 32'h40400000, 3'd0, {32'h3EAAAAAB, 5'b00001}, 31, "third_rne");
    do_op(32'h3F800000, 32'h40400000, 3'd1, {32'h3EAAAAAA, 5'b00001}, 31, "third_rtz");
    do_op(32'h3F800000, 32'h40400000, 3'd3, {32'h3EAAAAAB, 5'b00001}, 31, "third_rup");
    do_op(32'h3F800000, 32'h40400000, 3'd4, {32'h3EAAAAAB, 5'b00001}, 31, "third_rmm");
    do_op(32'hBF800000, 32'h40400000, 3'd2, {32'hBEAAAAAB, 5'b00001}, 31, "mthird_rdn");
    do_op(32'h3F800000, 32'h00000000, 3'd0, {32'h7F800000, 5'b01000}, 1, "div_zero");
    do_op(32'h00000000, 32'h00000000, 3'd0, {32'h7FC00000, 5'b10000}, 1, "zero_zero");
    do_op(32'h7F800000, 32'h7F800000, 3'd0, {32'h7FC00000, 5'b10000}, 1, "inf_inf");
    do_op(32'h7FC00000, 32'h3F800000, 3'd0, {32'h7FC00000, 5'b00000}, 1, "qnan");
    do_op(32'h7F800001, 32'h3F800000, 3'd0, {32'h7FC00000, 5'b10000}, 1, "snan");
    do_op(32'h7F7FFFFF, 32'h00800000, 3'd0, {32'h7F800000, 5'b00101}, -1, "ovf_rne");
    do_op(32'h7F7FFFFF, 32'h00800000, 3'd1, {32'h7F7FFFFF, 5'b00101}, -1, "ovf_rtz");
    do_op(32'h00800000, 32'h40000000, 3'd0, {32'h00400000, 5'b00000}, -1, "tiny_exact");
    do_op(32'h00800001, 32'h41000000, 3'd0, {32'h00100000, 5'b00011}, -1, "tiny_inexact");
    do_op(32'h00000001, 32'h00000001, 3'd0, {32'h3F800000, 5'b00000}, 77, "denorm_ops");

    // start held high and operands changed mid-flight must not disturb the operation
    exp_q.push_back({32'h3EAAAAAB, 5'b00001});
    @(negedge clk);
    operand_a = 32'h3F800000; operand_b = 32'h40400000; rounding_mode = 3'd0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    operand_a = 32'h40E00000; operand_b = 32'h3F000000;
    wait_done(lat);
    start = 1'b0;
    score("start_held", lat, 31);

    // reset in the middle of DIVIDE aborts the operation
    @(negedge clk);
    operand_a = 32'h40C00000; operand_b = 32'h40000000; rounding_mode = 3'd0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("abort result", 64'(result), 64'd0);
    check("abort flags", 64'({flag_invalid, flag_divzero, flag_overflow, flag_underflow,
                              flag_inexact}), 64'd0);
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      @(negedge clk);
      if (done) seen = 1;
    end
    check("abort no_done", 64'(seen), 64'd0);
    do_op(32'h40C00000, 32'h40000000, 3'd0, {32'h40400000, 5'b00000}, 31, "after_abort");

    // scoreboard: random operands against the reference model
    for (int i = 0; i < 250; i++) begin
      ka = int'($urandom_range(0, 6));
      kb = int'($urandom_range(0, 6));
      if (kb == 6 && $urandom_range(0, 3) != 0) kb = 1;
      ra = rand_operand(ka);
      rb = rand_operand(kb);
      rm = 3'($urandom_range(0, 7));
      do_op(ra, rb, rm, ref_div(ra, rb, rm), -1,
            $sformatf("rnd%0d %h/%h rm%0d", i, ra, rb, rm));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errs);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
